// File: rtl/pkt_ingress_buffer.sv
// pkt_ingress_buffer
// Store-and-forward byte buffer in front of the SRAM write port. Packets are
// written speculatively and become visible to the output side only once their
// eop byte is stored, so oversize, truncated and overflowing packets can be
// rewound and dropped without the SRAM controller ever seeing a fragment.
//
// state | meaning
// IDLE  | waiting for a sop beat
// RECV  | storing bytes of the current packet
// DROP  | discarding beats of a rejected packet until its eop
module pkt_ingress_buffer #(
    parameter int  DATA_W  = 8,
    parameter int  DEPTH   = 64,
    parameter int  MAX_PKT = 32,
    localparam int PTR_W   = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready,
    output logic              drop_pulse,
    output logic [PTR_W-1:0]  pkt_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = $clog2(MAX_PKT + 1);
    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN_P = LEN_W'(MAX_PKT);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t state, next_state;

    logic [DATA_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]    wr_tmp, wr_cmt, rd_ptr;
    logic [LEN_W-1:0]    len;
    logic                out_sop_r;
    logic                in_ready_r;

    logic                beat, pop, pop_eop;
    logic [PTR_W-1:0]    used, used_cmt, wr_addr;
    logic                full, full_cmt, len_max;
    logic [DATA_W:0]     rd_word;

    logic                wr_en, commit, drop, rewind, len_load, len_inc;

    // Space is judged on registered pointers only; a pop in this cycle does
    // not make room for a write in this cycle.
    assign beat     = in_valid & in_ready;
    assign used     = wr_tmp - rd_ptr;
    assign used_cmt = wr_cmt - rd_ptr;
    assign full     = (used == DEPTH_P);
    assign full_cmt = (used_cmt == DEPTH_P);
    assign len_max  = (len == MAX_LEN_P);
    assign wr_addr  = rewind ? wr_cmt : wr_tmp;

    assign in_ready  = in_ready_r;
    assign out_valid = (pkt_count != '0);
    assign rd_word   = mem[rd_ptr[AW-1:0]];
    assign out_data  = out_valid ? rd_word[DATA_W-1:0] : '0;
    assign out_eop   = out_valid & rd_word[DATA_W];
    assign out_sop   = out_valid & out_sop_r;
    assign pop       = out_valid & out_ready;
    assign pop_eop   = pop & rd_word[DATA_W];

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode for the input packet framer.
    always_comb begin
        next_state = state;
        if (beat) begin
            case (state)
                IDLE, DROP: begin
                    if (in_sop)
                        next_state = in_eop ? IDLE : (full ? DROP : RECV);
                    else if (state == DROP && in_eop)
                        next_state = IDLE;
                end
                RECV: begin
                    if (in_sop)
                        next_state = in_eop ? IDLE : (full_cmt ? DROP : RECV);
                    else if (len_max || full)
                        next_state = in_eop ? IDLE : DROP;
                    else if (in_eop)
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Datapath controls: write, commit, rewind and drop for the current beat.
    // A sop inside RECV rewinds first, then restarts at the committed pointer.
    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        drop     = 1'b0;
        rewind   = 1'b0;
        len_load = 1'b0;
        len_inc  = 1'b0;
        if (beat) begin
            case (state)
                IDLE, DROP: begin
                    if (in_sop) begin
                        if (full) begin
                            drop = 1'b1;
                        end else begin
                            wr_en    = 1'b1;
                            len_load = 1'b1;
                            commit   = in_eop;
                        end
                    end
                end
                RECV: begin
                    if (in_sop) begin
                        drop   = 1'b1;
                        rewind = 1'b1;
                        if (!full_cmt) begin
                            wr_en    = 1'b1;
                            len_load = 1'b1;
                            commit   = in_eop;
                        end
                    end else if (len_max || full) begin
                        drop   = 1'b1;
                        rewind = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        len_inc = 1'b1;
                        commit  = in_eop;
                    end
                end
                default: ;
            endcase
        end
    end

    // Packet storage; contents need no reset because only committed
    // entries are ever presented.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr[AW-1:0]] <= {in_eop, in_data};
    end

    // Pointers, packet length and the registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_tmp     <= '0;
            wr_cmt     <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            pkt_count  <= '0;
            drop_pulse <= 1'b0;
            out_sop_r  <= 1'b1;
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= 1'b1;
            drop_pulse <= drop;

            if (wr_en)       wr_tmp <= wr_addr + PTR_W'(1);
            else if (rewind) wr_tmp <= wr_cmt;

            if (commit) wr_cmt <= wr_addr + PTR_W'(1);

            if (len_load)     len <= LEN_W'(1);
            else if (len_inc) len <= len + LEN_W'(1);

            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                out_sop_r <= rd_word[DATA_W];
            end

            case ({commit, pop_eop})
                2'b10:   pkt_count <= pkt_count + PTR_W'(1);
                2'b01:   pkt_count <= pkt_count - PTR_W'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_ingress_buffer.sv
// Directed bench for pkt_ingress_buffer: a vector table for the short
// single-packet cases plus hand sequences for oversize, full-buffer and reset.
module tb_pkt_ingress_buffer;

    localparam int DATA_W = 8;
    localparam int PTR_W  = 7;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sop = 1'b0;
    logic              in_eop = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_ready = 1'b0;
    logic              drop_pulse;
    logic [PTR_W-1:0]  pkt_count;

    int total = 0;
    int bad   = 0;

    pkt_ingress_buffer #(.DATA_W(8), .DEPTH(64), .MAX_PKT(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse),
        .pkt_count  (pkt_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       e;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic       es;
        logic       ee;
        logic       edp;
        logic [6:0] epc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic s,
                                input logic e, input logic r, input logic ev,
                                input logic [7:0] ed, input logic es, input logic ee,
                                input logic edp, input logic [6:0] epc);
        vec_t t;
        t = '{v, d, s, e, r, ev, ed, es, ee, edp, epc};
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic es, input logic ee, input logic edp,
                           input logic [6:0] epc);
        chk({tag, " out_valid"},  32'(out_valid),  32'(ev));
        chk({tag, " out_data"},   32'(out_data),   32'(ed));
        chk({tag, " out_sop"},    32'(out_sop),    32'(es));
        chk({tag, " out_eop"},    32'(out_eop),    32'(ee));
        chk({tag, " drop_pulse"}, 32'(drop_pulse), 32'(edp));
        chk({tag, " pkt_count"},  32'(pkt_count),  32'(epc));
    endtask

    // Apply one beat, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic v, input logic [7:0] d, input logic s,
                        input logic e, input logic r);
        in_valid  = v;
        in_data   = d;
        in_sop    = s;
        in_eop    = e;
        out_ready = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 4-byte packet forwarded with 1-cycle latency
        add(1, 8'h11, 1, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h12, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h13, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h14, 0, 1, 1,  1, 8'h11, 1, 0, 0, 1);
        add(0, 8'h00, 0, 0, 1,  1, 8'h12, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 1,  1, 8'h13, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 1,  1, 8'h14, 0, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        // beat without sop in IDLE is discarded silently
        add(1, 8'h33, 0, 1, 1,  0, 8'h00, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        // missing eop: 11,12 dropped at the new sop, 21,22 forwarded
        add(1, 8'h11, 1, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h12, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        add(1, 8'h21, 1, 0, 1,  0, 8'h00, 0, 0, 1, 0);
        add(1, 8'h22, 0, 1, 1,  1, 8'h21, 1, 0, 0, 1);
        add(0, 8'h00, 0, 0, 1,  1, 8'h22, 0, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);
        // single-byte packet held under backpressure 0,0 then taken
        add(1, 8'hA5, 1, 1, 0,  1, 8'hA5, 1, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0,  1, 8'hA5, 1, 1, 0, 1);
        add(0, 8'h00, 0, 0, 0,  1, 8'hA5, 1, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1,  0, 8'h00, 0, 0, 0, 0);

        // reset state
        #2;
        chk_out("reset", 0, 8'h00, 0, 0, 0, 0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].e, vecs[i].r);
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es,
                    vecs[i].ee, vecs[i].edp, vecs[i].epc);
        end

        // oversize 33-byte packet: single drop on byte 33, then AA,BB passes
        for (int i = 1; i <= 33; i++) begin
            step(1, 8'(i), i == 1, i == 33, 1);
            chk($sformatf("oversize drop b%0d", i), 32'(drop_pulse), 32'(i == 33));
            chk($sformatf("oversize valid b%0d", i), 32'(out_valid), 32'd0);
        end
        step(0, 8'h00, 0, 0, 1);
        chk("oversize drop once", 32'(drop_pulse), 32'd0);
        step(1, 8'hAA, 1, 0, 1);
        chk_out("after-oversize AA in", 0, 8'h00, 0, 0, 0, 0);
        step(1, 8'hBB, 0, 1, 1);
        chk_out("after-oversize AA out", 1, 8'hAA, 1, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk_out("after-oversize BB out", 1, 8'hBB, 0, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk_out("after-oversize empty", 0, 8'h00, 0, 0, 0, 0);

        // fill the buffer with two 32-byte packets, overflow with a third
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 32; i++) begin
                step(1, 8'(p * 32 + i), i == 0, i == 31, 0);
                chk($sformatf("fill drop p%0d b%0d", p, i), 32'(drop_pulse), 32'd0);
            end
            chk($sformatf("fill pkt_count p%0d", p), 32'(pkt_count), 32'(p + 1));
        end
        step(1, 8'h5A, 1, 1, 0);
        chk("overflow drop", 32'(drop_pulse), 32'd1);
        chk("overflow pkt_count", 32'(pkt_count), 32'd2);
        step(0, 8'h00, 0, 0, 0);
        chk("overflow drop once", 32'(drop_pulse), 32'd0);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("drain valid %0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain data %0d", i), 32'(out_data), 32'(i));
            chk($sformatf("drain sop %0d", i), 32'(out_sop), 32'(i % 32 == 0));
            chk($sformatf("drain eop %0d", i), 32'(out_eop), 32'(i % 32 == 31));
            step(0, 8'h00, 0, 0, 1);
        end
        chk_out("drain empty", 0, 8'h00, 0, 0, 0, 0);

        // asynchronous reset mid-packet with one packet committed
        step(1, 8'h77, 1, 1, 0);
        chk("pre-reset pkt_count", 32'(pkt_count), 32'd1);
        step(1, 8'h01, 1, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_out("async reset", 0, 8'h00, 0, 0, 0, 0);
        chk("async reset in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        chk_out("held reset", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("release in_ready before edge", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        chk("release in_ready after edge", 32'(in_ready), 32'd1);
        step(1, 8'h01, 1, 0, 1);
        chk_out("post-reset 01 in", 0, 8'h00, 0, 0, 0, 0);
        step(1, 8'h02, 0, 1, 1);
        chk_out("post-reset 01 out", 1, 8'h01, 1, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk_out("post-reset 02 out", 1, 8'h02, 0, 1, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk_out("post-reset empty", 0, 8'h00, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
